fp_result_buffer: RTL and testbench
===================================

# fp_result_buffer

Elastic result stage wrapped around a fixed-latency, non-stallable FP conversion unit such as the 6-cycle float-to-int32 converter. It accepts tagged requests, fires the unit's "go" trigger only when a result slot is guaranteed, and captures each "done"/result pair into a FIFO. The consumer can therefore apply backpressure without losing results. It sits between the issue logic and the converter's output, in-order, one operation per cycle peak.

## Interface
- DEPTH, 8: result/tag slots; power of two, ≥ 2.
- TAG_W, 4: width of request tag carried alongside each operation.
- DATA_W, 32: result width.
- LATENCY, 6: fixed go→done latency of the attached unit; sets the post-reset drain window.
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle if req_valid.
- req_tag  in  TAG_W  tag returned with the result.
- unit_go  out  1  "go" trigger to unit; operand is routed to the unit externally, same cycle.
- unit_done  in  1  unit "done" trigger.
- unit_result  in  DATA_W  unit result, valid when unit_done.
- resp_valid  out  1  FIFO non-empty.
- resp_ready  in  1  consumer pops head when resp_valid.
- resp_data  out  DATA_W  head result.
- resp_tag  out  TAG_W  head tag.
- err  out  1  sticky: unit_done seen with no pending tag.

## Operation
- Accept condition: fire = req_valid & req_ready; unit_go = fire (combinational).
- req_ready = ~draining & ((fifo_count + inflight) < DEPTH), with both counters registered; no combinational path from req_valid or resp_ready.
- On fire: push req_tag into the pending-tag queue (depth DEPTH) and increment inflight.
- On unit_done & ~draining:
  - If inflight > 0: pop the pending tag, push {tag, unit_result} into the result FIFO, decrement inflight.
  - If inflight = 0: set err; the FIFO is unchanged.
- Pop: resp_valid & resp_ready removes the head.
- Simultaneous events: fire, done and pop may all occur in one cycle. Each counter updates by its net change (+1, −1 or 0). Overflow is impossible by construction of req_ready.
- Push while full never occurs. Pop with FIFO empty is ignored (resp_valid = 0).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits so that the value DEPTH is representable.
- Drain FSM, two states:
  - DRAIN: entered on reset. A counter loads LATENCY−1 and decrements each cycle. The state is left when the counter reaches 0, i.e. after LATENCY cycles with reset low.
  - RUN: normal operation.
  - Purpose: the unit's trigger pipeline is not reset, so stale dones are discarded during DRAIN, and req_ready = 0 there.
- Reset mid-operation: all in-flight and buffered results are discarded. Counters and pointers go to 0, err clears, and the FSM enters DRAIN.

## Timing
- Reset values: req_ready 0, unit_go 0, resp_valid 0, resp_data 0, resp_tag 0, err 0.
- First possible req_ready = 1: the LATENCY-th cycle after the first cycle with reset low (cycle index LATENCY−1, counting from 0).
- FIFO write on the done edge; resp_valid rises on the next cycle. The head registers are show-ahead: the head is stable while resp_valid & ~resp_ready.
- End-to-end latency with an idle FIFO: request accepted at cycle t gives resp_valid at t+LATENCY+1.
- Throughput: one request per cycle sustained while resp_ready = 1 and DEPTH > LATENCY+1. With DEPTH ≤ LATENCY+1, throughput is capped at DEPTH per LATENCY+1 cycles.
- err sets on the cycle after the offending done and stays high until reset.

## Test plan
- Reset then idle: hold reset 2 cycles and release. Expect req_ready = 0 for cycles 0..4, req_ready = 1 at cycle 5, and all other outputs 0 throughout.
- Single op: tag 3, done driven 6 cycles after go with result 0x0000_002A. Expect resp_valid on the next cycle with resp_tag 3 and resp_data 0x2A; a pop on that cycle gives resp_valid 0 on the following cycle.
- Backpressure fill: resp_ready = 0, req_valid = 1 continuously, tags 0..9. Expect exactly 8 fires (tags 0..7), after which req_ready = 0. Then set resp_ready = 1: outputs come in order 0..7, req_ready returns, and tags 8, 9 follow in order.
- Simultaneous fire/done/pop every cycle at steady state with DEPTH = 8: counts remain constant and 100 consecutive results come out in order with no loss.
- Stray done: raise unit_done with nothing in flight. Expect err = 1 on the next cycle, the FIFO unchanged and err held; reset clears it.
- Reset mid-stream: 4 ops in flight and 2 buffered, then assert reset. Expect resp_valid = 0 immediately after. Dones arriving within 6 cycles are ignored with err staying 0 and no responses produced.

Source files
------------

// File: rtl/fp_result_buffer.sv
// Elastic result buffer for a fixed-latency, non-stallable FP conversion unit.
// Issues "go" only when a result slot is guaranteed, then captures done/result pairs into a tagged FIFO.
module fp_result_buffer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              unit_go,
  input  logic              unit_done,
  input  logic [DATA_W-1:0] unit_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(LATENCY - 1);
  localparam logic [CW:0]   OCC_LIMIT  = (CW+1)'(DEPTH);

  localparam logic [0:0] ST_DRAIN = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // Pending-tag queue: one entry per operation inside the unit.
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    tw_q, tw_d, tr_q, tr_d;
  logic [CW-1:0]    inflight_q, inflight_d;

  // Result FIFO.
  logic [DATA_W-1:0] res_data_mem [DEPTH];
  logic [TAG_W-1:0]  res_tag_mem  [DEPTH];
  logic [PW-1:0]     rw_q, rw_d, rr_q, rr_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;

  logic err_q, err_d;

  logic        draining;
  logic [CW:0] occupancy;
  logic        fire;
  logic        done_ok;
  logic        retire;
  logic        stray;
  logic        pop;

  always_comb begin
    draining  = (state_q == ST_DRAIN) && (dcnt_q != '0);
    occupancy = {1'b0, fcnt_q} + {1'b0, inflight_q};
    // Gated by reset so no "go" escapes in the reset cycle; its done would land after the drain window.
    req_ready = ~reset & ~draining & (occupancy < OCC_LIMIT);
    fire      = req_valid & req_ready;
    unit_go   = fire;
    done_ok   = unit_done & ~draining;
    retire    = done_ok & (inflight_q != '0);
    stray     = done_ok & (inflight_q == '0);
    resp_valid = (fcnt_q != '0);
    pop        = resp_valid & resp_ready;
    resp_data  = resp_valid ? res_data_mem[rr_q] : '0;
    resp_tag   = resp_valid ? res_tag_mem[rr_q]  : '0;
    err        = err_q;
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (state_q == ST_DRAIN) begin
      if (dcnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        dcnt_d = dcnt_q - DW'(1);
      end
    end
  end

  always_comb begin
    tw_d       = fire   ? tw_q + PW'(1) : tw_q;
    tr_d       = retire ? tr_q + PW'(1) : tr_q;
    rw_d       = retire ? rw_q + PW'(1) : rw_q;
    rr_d       = pop    ? rr_q + PW'(1) : rr_q;
    inflight_d = inflight_q;
    case ({fire, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    fcnt_d = fcnt_q;
    case ({retire, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
    err_d = err_q | stray;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_DRAIN;
      dcnt_q     <= DRAIN_LOAD;
      tw_q       <= '0;
      tr_q       <= '0;
      rw_q       <= '0;
      rr_q       <= '0;
      inflight_q <= '0;
      fcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      tw_q       <= tw_d;
      tr_q       <= tr_d;
      rw_q       <= rw_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      fcnt_q     <= fcnt_d;
      err_q      <= err_d;
    end
  end

  // Storage arrays need no reset: occupancy counters qualify every read.
  always_ff @(posedge clock) begin
    if (fire) begin
      tag_mem[tw_q] <= req_tag;
    end
    if (retire) begin
      res_data_mem[rw_q] <= unit_result;
      res_tag_mem[rw_q]  <= tag_mem[tr_q];
    end
  end

endmodule

// File: tb/tb_fp_result_buffer.sv
// Bench for fp_result_buffer: emulates the fixed-latency unit and checks every cycle against a queue-based model.
module tb_fp_result_buffer;

  localparam int DEPTH = 8;
  localparam int LAT   = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_tag = '0;
  logic        unit_go;
  logic        unit_done = 1'b0;
  logic [31:0] unit_result = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [3:0]  resp_tag;
  logic        err;

  always #5 clock = ~clock;

  fp_result_buffer #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(32), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .unit_go(unit_go), .unit_done(unit_done), .unit_result(unit_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .err(err)
  );

  logic [39:0] dut_vec;
  assign dut_vec = {req_ready, unit_go, resp_valid, resp_tag, resp_data, err};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: cycles of drain left, pending tags, buffered {tag,data}, sticky error.
  int          m_drain = LAT - 1;
  logic [3:0]  m_pend[$];
  logic [35:0] m_fifo[$];
  bit          m_err = 0;
  // Emulated unit: go in cycle t produces done in cycle t+LAT.
  bit          pv[LAT];
  logic [31:0] pd[LAT];
  bit          stray = 0;
  bit          force_en = 0;
  logic [31:0] force_val = '0;
  int          fires = 0;
  logic [3:0]  out_tags[$];
  logic [3:0]  issued[$];

  function automatic bit m_ready();
    return !reset && (m_drain == 0) && ((m_fifo.size() + m_pend.size()) < DEPTH);
  endfunction

  function automatic logic [39:0] exp_vec();
    logic [35:0] h;
    h = (m_fifo.size() != 0) ? m_fifo[0] : 36'h0;
    return {m_ready(), m_ready() && req_valid, m_fifo.size() != 0, h, m_err};
  endfunction

  task automatic settle();
    unit_done   = pv[LAT-1] | stray;
    unit_result = pv[LAT-1] ? pd[LAT-1] : (stray ? $urandom : 32'h0);
    #1;
    if (unit_go === 1'b1) fires++;
    if (resp_valid === 1'b1 && resp_ready) out_tags.push_back(resp_tag);
  endtask

  task automatic advance();
    bit go, pop;
    logic [3:0] t;
    go = m_ready() && req_valid;
    if (go) issued.push_back(req_tag);
    @(posedge clock);
    if (reset) begin
      m_pend.delete();
      m_fifo.delete();
      m_err   = 0;
      m_drain = LAT - 1;
    end else begin
      pop = (m_fifo.size() > 0) && resp_ready;
      if (unit_done && m_drain == 0) begin
        if (m_pend.size() > 0) begin
          t = m_pend.pop_front();
          m_fifo.push_back({t, unit_result});
        end else begin
          m_err = 1;
        end
      end
      if (pop) m_fifo.delete(0);
      if (go) m_pend.push_back(req_tag);
      if (m_drain > 0) m_drain--;
    end
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = go;
    pd[0] = force_en ? force_val : $urandom;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 0; resp_ready = 0;
    repeat (2) begin settle(); advance(); end
    reset = 0;
    for (int c = 0; c < 8; c++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      n_tests++;
      if ({req_ready, unit_go, resp_valid, resp_tag, resp_data, err} !== {(c >= LAT - 1), 39'h0}) begin
        n_fail++; $display("FAIL reset_ready_cycle cyc=%0d got=%h exp_ready=%0d", c, dut_vec, (c >= LAT - 1));
      end
      advance();
    end
  endtask

  task automatic test_single_op();
    req_valid = 1; req_tag = 4'd3; force_en = 1; force_val = 32'h0000_002A; resp_ready = 0;
    settle();
    n_tests++;
    if (unit_go !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL single_go got=%h exp=%h", dut_vec, exp_vec());
    end
    advance();
    req_valid = 0; force_en = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      resp_ready = (k == LAT + 1);
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL single_cycle k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      n_tests++;
      if (k == LAT + 1) begin
        if ({resp_valid, resp_tag, resp_data} !== {1'b1, 4'd3, 32'h2A}) begin
          n_fail++; $display("FAIL single_resp got v=%b tag=%0d data=%h exp v=1 tag=3 data=2a", resp_valid, resp_tag, resp_data);
        end
      end else if (resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL single_valid k=%0d got=%b exp=0", k, resp_valid);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int ntag = 0;
    fires = 0; out_tags.delete(); resp_ready = 0;
    for (int c = 0; c < 20; c++) begin
      req_valid = (ntag < 10); req_tag = 4'(ntag);
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL bp_fill cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (m_ready() && req_valid) ntag++;
      advance();
    end
    n_tests++;
    if (fires != 8 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full fires=%0d ready=%b exp fires=8 ready=0", fires, req_ready);
    end
    resp_ready = 1;
    for (int c = 0; c < 80 && out_tags.size() < 10; c++) begin
      req_valid = (ntag < 10); req_tag = 4'(ntag);
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (m_ready() && req_valid) ntag++;
      advance();
    end
    req_valid = 0;
    n_tests++;
    if (out_tags.size() != 10) begin
      n_fail++; $display("FAIL bp_timeout got=%0d responses exp=10", out_tags.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (out_tags[i] !== 4'(i)) begin
          n_fail++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, out_tags[i], i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issued.delete(); out_tags.delete(); resp_ready = 1;
    for (int c = 0; c < 120; c++) begin
      req_valid = 1; req_tag = 4'($urandom);
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL b2b cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (c >= LAT + 1) begin
        n_tests++;
        if ({unit_go, resp_valid, req_ready} !== 3'b111) begin
          n_fail++; $display("FAIL b2b_steady cyc=%0d got go/valid/ready=%b%b%b exp=111", c, unit_go, resp_valid, req_ready);
        end
      end
      advance();
    end
    req_valid = 0;
    for (int c = 0; c < LAT + 4; c++) begin settle(); advance(); end
    for (int i = 0; i < issued.size() && i < out_tags.size(); i++)
      if (out_tags[i] !== issued[i]) bad++;
    n_tests++;
    if (out_tags.size() < 100 || out_tags.size() != issued.size() || bad != 0) begin
      n_fail++; $display("FAIL b2b_stream got=%0d results bad=%0d exp=%0d results bad=0", out_tags.size(), bad, issued.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid  = ($urandom_range(3) != 0);
      req_tag    = 4'($urandom);
      resp_ready = ($urandom_range(2) != 0);
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
    end
    req_valid = 0; resp_ready = 1;
    for (int c = 0; c < LAT + DEPTH + 4; c++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_stray_done();
    resp_ready = 0; req_valid = 1; req_tag = 4'd9;
    settle(); advance();
    req_valid = 0;
    for (int c = 0; c < LAT + 2; c++) begin settle(); advance(); end
    stray = 1;
    settle();
    n_tests++;
    if (dut_vec !== exp_vec() || err !== 1'b0) begin
      n_fail++; $display("FAIL stray_same_cycle got=%h exp=%h", dut_vec, exp_vec());
    end
    advance();
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      n_tests++;
      if ({err, resp_valid, resp_tag} !== {1'b1, 1'b1, 4'd9} || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL stray_hold cyc=%0d got=%h exp err=1 valid=1 tag=9", c, dut_vec);
      end
      advance();
    end
    reset = 1;
    settle(); advance();
    reset = 0;
    for (int c = 0; c < LAT; c++) begin
      settle();
      n_tests++;
      if (err !== 1'b0 || resp_valid !== 1'b0 || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL stray_reset_clear cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_reset_midstream();
    resp_ready = 0;
    for (int c = 0; c < 22; c++) begin
      req_valid = (c < 6); req_tag = 4'(c + 2); reset = (c == 8);
      settle();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL midreset cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      if (c == 8) begin
        n_tests++;
        if ({resp_valid, resp_tag} !== {1'b1, 4'd2}) begin
          n_fail++; $display("FAIL midreset_buffered got v=%b tag=%0d exp v=1 tag=2", resp_valid, resp_tag);
        end
      end else if (c > 8) begin
        n_tests++;
        if (resp_valid !== 1'b0 || err !== 1'b0) begin
          n_fail++; $display("FAIL midreset_discard cyc=%0d got v=%b err=%b exp v=0 err=0", c, resp_valid, err);
        end
      end
      advance();
    end
    reset = 0;
  endtask

  initial begin
    for (int k = 0; k < LAT; k++) begin pv[k] = 0; pd[k] = '0; end
    @(negedge clock);
    test_reset();
    test_single_op();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_stray_done();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
